// File: rtl/llm_signal_conditioner.sv
// Synchronises, debounces and priority-resolves the raw green/red/yellow trigger lines.
// Optional GLITCH_COUNT_EN adds a saturating glitch_count output.
module llm_signal_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_green,
  input  logic       raw_red,
  input  logic       raw_yellow,
  output logic       green,
  output logic       red,
  output logic       yellow,
  output logic       conflict,
`ifdef GLITCH_COUNT_EN
  output logic [7:0] glitch_count,
`endif
  output logic       stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  // Channel index: 0 green, 1 red, 2 yellow.
  logic [2:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             sync_x;
  logic [2:0]             db_q, db_d;
  logic [CntW-1:0]        cnt_q [3];
  logic [CntW-1:0]        cnt_d [3];
  logic [2:0]             glitch;
  logic                   quiet;

  assign raw = {raw_yellow, raw_red, raw_green};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        sync_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      db_q <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
        cnt_q[c]  <= cnt_d[c];
      end
      db_q <= db_d;
    end
  end

  always_comb begin
    db_d   = db_q;
    glitch = '0;
    quiet  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sync_x[c] = sync_q[c][SYNC_STAGES-1];
      cnt_d[c]  = '0;
      if (sync_x[c] == db_q[c]) begin
        // Returning to the debounced level mid-count is a rejected glitch.
        glitch[c] = (cnt_q[c] != '0);
      end else if (cnt_q[c] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        db_d[c] = sync_x[c];
      end else begin
        cnt_d[c] = cnt_q[c] + CntW'(1);
      end
      if (cnt_q[c] != '0 || sync_x[c] != db_q[c]) begin
        quiet = 1'b0;
      end
    end
  end

  // Red beats yellow beats green; all driven from the same debounced snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      green    <= 1'b0;
      red      <= 1'b0;
      yellow   <= 1'b0;
      conflict <= 1'b0;
      stable   <= 1'b1;
    end else begin
      red      <= db_q[1];
      yellow   <= db_q[2] & ~db_q[1];
      green    <= db_q[0] & ~db_q[2] & ~db_q[1];
      conflict <= (db_q[0] & db_q[1]) | (db_q[0] & db_q[2]) | (db_q[1] & db_q[2]);
      stable   <= quiet;
    end
  end

`ifdef GLITCH_COUNT_EN
  logic [9:0] gc_sum;

  always_comb begin
    gc_sum = {2'b00, glitch_count} + 10'(glitch[0]) + 10'(glitch[1]) + 10'(glitch[2]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      glitch_count <= 8'd0;
    end else begin
      glitch_count <= (gc_sum > 10'd255) ? 8'hff : gc_sum[7:0];
    end
  end
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
`endif

endmodule

// File: tb/tb_llm_signal_conditioner.sv
// Bench for llm_signal_conditioner: default instance plus a DEBOUNCE_CYCLES=1 instance on
// shared inputs, checked every cycle against a sample-history reference model.
module tb_llm_signal_conditioner;

  localparam int S    = 2;
  localparam int HMAX = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic raw_green = 1'b0, raw_red = 1'b0, raw_yellow = 1'b0;
  logic g4, r4, y4, c4, s4;
  logic g1, r1, y1, c1, s1;
`ifdef GLITCH_COUNT_EN
  logic [7:0] gc4, gc1;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  llm_signal_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(S)) dut4 (
    .clock(clock), .reset(reset), .raw_green(raw_green), .raw_red(raw_red),
    .raw_yellow(raw_yellow), .green(g4), .red(r4), .yellow(y4), .conflict(c4),
`ifdef GLITCH_COUNT_EN
    .glitch_count(gc4),
`endif
    .stable(s4)
  );

  llm_signal_conditioner #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(S)) dut1 (
    .clock(clock), .reset(reset), .raw_green(raw_green), .raw_red(raw_red),
    .raw_yellow(raw_yellow), .green(g1), .red(r1), .yellow(y1), .conflict(c1),
`ifdef GLITCH_COUNT_EN
    .glitch_count(gc1),
`endif
    .stable(s1)
  );

  // raw_h[t] = {yellow, red, green} driven before edge t (edge 1 = first edge after reset).
  logic [2:0] raw_h [HMAX];
  int         t;
  logic [2:0] db4, db1;
  int         mgc4, mgc1;

  function automatic logic samp(input int c, input int te);
    if (te - S < 1) return 1'b0;
    return raw_h[te - S][c];
  endfunction

  // Debounced level flips once the last d synchronised samples all disagree with it;
  // a glitch is a sample matching it right after one that disagreed.
  task automatic model_edge(input int d, inout logic [2:0] db, inout int gc,
                            output logic [4:0] exp);
    logic [2:0] nd;
    int         gl;
    logic       quiet;
    logic       all_diff;
    nd    = db;
    gl    = 0;
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (samp(c, t) != db[c] || samp(c, t - 1) != db[c]) quiet = 1'b0;
      if (samp(c, t) == db[c] && samp(c, t - 1) != db[c]) gl++;
      all_diff = 1'b1;
      for (int k = 0; k < d; k++) begin
        if (samp(c, t - k) == db[c]) all_diff = 1'b0;
      end
      if (all_diff) nd[c] = ~db[c];
    end
    exp[0] = db[0] & ~db[1] & ~db[2];
    exp[1] = db[1];
    exp[2] = db[2] & ~db[1];
    exp[3] = quiet;
    exp[4] = (int'(db[0]) + int'(db[1]) + int'(db[2])) >= 2;
    gc = (gc + gl > 255) ? 255 : gc + gl;
    db = nd;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at t=%0d", tag, obs, exp, t);
  endtask

  task automatic check_vec(input string pre, input logic [4:0] obs, input logic [4:0] exp);
    string names [5];
    names = '{"green", "red", "yellow", "stable", "conflict"};
    for (int i = 0; i < 5; i++) check({pre, ".", names[i]}, 8'(obs[i]), 8'(exp[i]));
  endtask

  task automatic step(input logic g, input logic r, input logic y);
    logic [4:0] e4, e1;
    t++;
    if (t >= HMAX) $fatal(1, "FAIL history overflow t=%0d", t);
    raw_h[t]   = {y, r, g};
    raw_green  = g;
    raw_red    = r;
    raw_yellow = y;
    @(posedge clock);
    model_edge(4, db4, mgc4, e4);
    model_edge(1, db1, mgc1, e1);
    @(negedge clock);
    check_vec("d4", {c4, s4, y4, r4, g4}, e4);
    check_vec("d1", {c1, s1, y1, r1, g1}, e1);
`ifdef GLITCH_COUNT_EN
    check("d4.glitch_count", gc4, 8'(mgc4));
    check("d1.glitch_count", gc1, 8'(mgc1));
`endif
  endtask

  // Asserted at a negedge, so it lands mid-cycle relative to the active edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_vec("rst.d4", {c4, s4, y4, r4, g4}, 5'b01000);
    check_vec("rst.d1", {c1, s1, y1, r1, g1}, 5'b01000);
`ifdef GLITCH_COUNT_EN
    check("rst.glitch_count", gc4, 8'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    t     = 0;
    db4   = '0;
    db1   = '0;
    mgc4  = 0;
    mgc1  = 0;
  endtask

  initial begin
    logic [2:0] lv;
    @(negedge clock);
    do_reset();

    // Green held from edge 1: visible after edge 7, stable low over edges 3..6.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 2) check("lat.stable_e2", 8'(s4), 8'd1);
      if (i == 3) check("lat.stable_e3", 8'(s4), 8'd0);
      if (i == 6) check("lat.green_e6", 8'(g4), 8'd0);
      if (i == 7) check("lat.green_e7", 8'(g4), 8'd1);
      if (i == 7) check("lat.stable_e7", 8'(s4), 8'd1);
    end
    // Yellow joins: takes over from green on the same edge, conflict follows.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    check("prio.yellow", 8'(y4), 8'd1);
    check("prio.conflict", 8'(c4), 8'd1);

    // Short red pulse never reaches red.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("pulse.red", 8'(r4), 8'd0);
    end
`ifdef GLITCH_COUNT_EN
    check("pulse.glitch_count", gc4, 8'd1);
`endif

    // All three rise together: red wins; dropping red hands over to yellow.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    check("all.red", 8'(r4), 8'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    check("all.yellow", 8'(y4), 8'd1);

    // Reset mid-count with red held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check("rstmid.red", 8'(r4), 8'd1);

    // Random toggling with biased hold times.
    do_reset();
    lv = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(4, 0) == 0) lv[c] = ~lv[c];
      end
      step(lv[0], lv[1], lv[2]);
    end

    // 300 one-cycle yellow pulses saturate the glitch counter.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
`ifdef GLITCH_COUNT_EN
    check("sat.glitch_count", gc4, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
